ram_banked_2p: RTL
==================

Name: ram_banked_2p

Overview:
- Pseudo-dual-port memory built from NUM_BANK single-port banks, with word-interleaved addressing.
- Accepts one write and one read request per cycle, each with a valid/ready handshake. Different-bank requests proceed in parallel.
- Same-bank conflicts are arbitrated: write has priority, with a starvation guard for reads.
- Read data is held at the output until the next read returns. Successor to the single-macro RAM wrapper for the CPM feature/weight buffers.

Parameters:
- SRAM_BIT, 8, bits per byte lane
- SRAM_BYTE, 4, byte lanes per word
- SRAM_WORD, 1024, total words across all banks; must be a multiple of NUM_BANK
- NUM_BANK, 4, number of banks; power of two, at least 1
- STARVE_MAX, 4, consecutive read stalls before the read wins one cycle; at least 1
- SRAM_WIDTH, SRAM_BIT*SRAM_BYTE, derived word width
- ADDR_W, $clog2(SRAM_WORD), derived address width
- BANK_W, max(1,$clog2(NUM_BANK)), derived bank-select width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle when high together with wr_valid
- wr_addr  in  ADDR_W  write word address
- wr_data  in  SRAM_WIDTH  write data
- wr_be  in  SRAM_BYTE  byte-lane write enables; bit i covers bits [i*SRAM_BIT +: SRAM_BIT]
- rd_valid  in  1  read request
- rd_ready  out  1  read accepted this cycle when high together with rd_valid
- rd_addr  in  ADDR_W  read word address
- rd_dvld  out  1  one-cycle pulse: rd_data carries new read data
- rd_data  out  SRAM_WIDTH  read data; holds its value between reads

Behaviour:
- Bank select is addr[BANK_W-1:0]; the in-bank row is addr[ADDR_W-1:BANK_W]. With NUM_BANK=1 there is no bank field and every request pair is a conflict.
- Conflict: wr_valid & rd_valid & (wr bank == rd bank). No conflict means wr_ready=1 and rd_ready=1, combinationally.
- Conflict with starve_cnt < STARVE_MAX: wr_ready=1, rd_ready=0, and starve_cnt increments.
- Conflict with starve_cnt == STARVE_MAX: wr_ready=0, rd_ready=1, and starve_cnt clears.
- starve_cnt also clears on any accepted read. It holds otherwise.
- The ready outputs depend only on the current valids, the addresses and starve_cnt. A requester may drop valid without penalty.
- Accepted write: the row is updated at the clock edge, only for lanes with wr_be=1. wr_be=0 with an accepted write is a legal no-op.
- Accepted read: the bank is read at the edge. rd_dvld=1 and rd_data=new word in the next cycle (latency 1).
- When rd_dvld=0, rd_data holds the last returned word via the lock register.
- Read and write to the same address can only be simultaneous under a conflict, so they are serialised:
  - write-priority cycle: the read is issued later and returns the new data;
  - starvation cycle: the read returns the old data and the write lands on the next accept.
- Reads to different banks in the same cycle as a write see pre-write contents only if the address is different. The same address always implies the same bank.
- Reset values: rd_dvld=0, rd_data=0, starve_cnt=0. The ready outputs follow the combinational rules even during reset, except that both are 0 while rst_n=0.
- Reset mid-operation: any in-flight read return is dropped (no rd_dvld after release). Memory contents are not cleared and are undefined after power-up.
- Out-of-range rows (SRAM_WORD/NUM_BANK not a power of two) are ignored on write and return 0 on read.

Optional Feature:
- RAM_OUT_REG_EN defined: one extra output register stage is added. Read latency becomes 2 cycles; rd_dvld and rd_data are both delayed one cycle; the hold behaviour is unchanged.
- Undefined: latency is 1 cycle, as described above.

Decomposition:
- Shared package (cpm_ram_pkg):
  - helper function for bank/row split;
  - localparam rules for BANK_W and ROW_W;
  - arbitration-grant encoding constants (GNT_NONE, GNT_WR, GNT_RD, GNT_BOTH).
- One sub-module, ram_sp_bank: single-port behavioural bank.
  - Ports: clk, ceb, web, bweb, a, d, q.
  - Behaviour: byte-masked write; one-cycle read.
  - Instantiated NUM_BANK times via generate. Hard-macro swap happens inside it.
- Top level: arbitration, starve_cnt, the output mux (from the delayed bank select), and the lock register.

Test Plan:
- Write 0xA5A5A5A5 at addr 5 with wr_be=4'hF, then read addr 5 → rd_dvld one cycle after accept, rd_data=0xA5A5A5A5. The value holds for 3 idle cycles.
- Write addr 8 with 0x11223344, then write addr 8 with 0xFFFFFFFF and wr_be=4'b0101, then read → 0x11FF33FF.
- Same cycle: write addr 1 and read addr 2 (different banks) → both ready=1. The read returns the prior contents of addr 2.
- Continuous writes to bank 0 with a read of addr 4 held valid:
  - rd_ready=0 for 4 cycles;
  - 5th cycle: rd_ready=1 and wr_ready=0;
  - rd_dvld follows one cycle later.
- Assert rst_n low the cycle after a read accept → no rd_dvld after release, rd_data=0. Memory written before reset still reads back.
- With RAM_OUT_REG_EN: repeat scenario 1 → rd_dvld is 2 cycles after accept, with identical data.

Source files
------------

// File: rtl/cpm_ram_pkg.sv
// -----------------------------------------------------------------------------
// cpm_ram_pkg
// Shared definitions for the banked CPM buffer RAM.
//   - calc_bank_w / calc_sel_w / calc_row_w : width rules for bank and row fields
//   - addr_bank / addr_row                  : word-interleaved address split
//   - GNT_* : arbitration grant encoding (bit 0 = write granted,
//             bit 1 = read granted)
// -----------------------------------------------------------------------------
package cpm_ram_pkg;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_WR   = 2'b01;
   localparam logic [1:0] GNT_RD   = 2'b10;
   localparam logic [1:0] GNT_BOTH = 2'b11;

   // Number of address bits consumed by the bank field (0 for a single bank).
   function automatic int calc_sel_w(input int nb);
      return (nb > 1) ? $clog2(nb) : 0;
   endfunction

   // Width of the bank-select signal; kept at least 1 bit so it is a legal vector.
   function automatic int calc_bank_w(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

   // In-bank row width, never narrower than 1 bit.
   function automatic int calc_row_w(input int aw, input int nb);
      return ((aw - calc_sel_w(nb)) > 0) ? (aw - calc_sel_w(nb)) : 1;
   endfunction

   // Low address bits select the bank (word interleaving).
   function automatic logic [31:0] addr_bank(input logic [31:0] addr, input int nb);
      return addr & 32'(nb - 1);
   endfunction

   // Remaining upper bits form the row inside the bank.
   function automatic logic [31:0] addr_row(input logic [31:0] addr, input int nb);
      return addr >> calc_sel_w(nb);
   endfunction

endpackage

// File: rtl/ram_sp_bank.sv
// -----------------------------------------------------------------------------
// ram_sp_bank
// Single-port behavioural RAM bank with bit-masked write and one-cycle read.
// This is the place to swap in a hard SRAM macro.
// Ports:
//   clk  : clock
//   ceb  : chip enable, active-low
//   web  : write enable, active-low (read when high and ceb low)
//   bweb : per-bit write mask, active-low
//   a    : row address
//   d    : write data
//   q    : read data, updated one cycle after a read access, held otherwise
// Rows at or beyond DEPTH are ignored on write and read back as zero.
// -----------------------------------------------------------------------------
module ram_sp_bank #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             ceb,
   input  logic             web,
   input  logic [WIDTH-1:0] bweb,
   input  logic [AW-1:0]    a,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             in_range;

   assign in_range = ({1'b0, a} < DEPTH_L);

   always_ff @(posedge clk) begin
      if (!ceb) begin
         if (!web) begin
            if (in_range) begin
               mem[a] <= (mem[a] & bweb) | (d & ~bweb);
            end
         end else begin
            q <= in_range ? mem[a] : '0;
         end
      end
   end

endmodule

// File: rtl/ram_banked_2p.sv
// -----------------------------------------------------------------------------
// ram_banked_2p
// Pseudo-dual-port RAM built from NUM_BANK single-port banks with
// word-interleaved addressing. One write and one read request per cycle;
// different-bank requests proceed in parallel, same-bank conflicts go to the
// write unless the read has been stalled STARVE_MAX times in a row.
//
// Handshake: a request is accepted in a cycle where valid and ready are both
// high. Ready depends only on the current valids, addresses and the starvation
// count, so a requester may drop valid at any time without penalty.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_valid / wr_ready : write request / accept
//   wr_addr, wr_data    : write word address and data
//   wr_be               : byte-lane write enables
//   rd_valid / rd_ready : read request / accept
//   rd_addr             : read word address
//   rd_dvld             : one-cycle pulse, rd_data carries new read data
//   rd_data             : read data, held between reads
//
// Build option: RAM_OUT_REG_EN adds one output register stage (read latency 2).
// -----------------------------------------------------------------------------
module ram_banked_2p
   import cpm_ram_pkg::*;
#(
   parameter  int SRAM_BIT   = 8,
   parameter  int SRAM_BYTE  = 4,
   parameter  int SRAM_WORD  = 1024,
   parameter  int NUM_BANK   = 4,
   parameter  int STARVE_MAX = 4,
   localparam int SRAM_WIDTH = SRAM_BIT * SRAM_BYTE,
   localparam int ADDR_W     = $clog2(SRAM_WORD),
   localparam int BANK_W     = calc_bank_w(NUM_BANK)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [SRAM_WIDTH-1:0] wr_data,
   input  logic [SRAM_BYTE-1:0]  wr_be,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic                  rd_dvld,
   output logic [SRAM_WIDTH-1:0] rd_data
);

   localparam int ROW_W = calc_row_w(ADDR_W, NUM_BANK);
   localparam int DEPTH = SRAM_WORD / NUM_BANK;
   localparam int SC_W  = $clog2(STARVE_MAX + 1);

   // ---------------------------------------------------------------------------
   // Address split
   // ---------------------------------------------------------------------------
   logic [BANK_W-1:0] wr_bank, rd_bank;
   logic [ROW_W-1:0]  wr_row, rd_row;

   assign wr_bank = BANK_W'(addr_bank(32'(wr_addr), NUM_BANK));
   assign rd_bank = BANK_W'(addr_bank(32'(rd_addr), NUM_BANK));
   assign wr_row  = ROW_W'(addr_row(32'(wr_addr), NUM_BANK));
   assign rd_row  = ROW_W'(addr_row(32'(rd_addr), NUM_BANK));

   // ---------------------------------------------------------------------------
   // Arbitration and starvation guard
   // ---------------------------------------------------------------------------
   logic [SC_W-1:0] starve_q, starve_d;
   logic [1:0]      gnt;
   logic            conflict;
   logic            starve_full;
   logic            wr_fire, rd_fire;

   assign conflict    = wr_valid & rd_valid & (wr_bank == rd_bank);
   assign starve_full = (starve_q == SC_W'(STARVE_MAX));

   always_comb begin
      gnt = GNT_NONE;
      if (rst_n) begin
         if (conflict) begin
            gnt = starve_full ? GNT_RD : GNT_WR;
         end else begin
            gnt = GNT_BOTH;
         end
      end
   end

   assign wr_ready = (gnt == GNT_WR) || (gnt == GNT_BOTH);
   assign rd_ready = (gnt == GNT_RD) || (gnt == GNT_BOTH);
   assign wr_fire  = wr_valid & wr_ready;
   assign rd_fire  = rd_valid & rd_ready;

   // Counts consecutive conflict cycles lost by the read; the read that wins
   // (or any other accepted read) restarts the count.
   always_comb begin
      starve_d = starve_q;
      if (conflict) begin
         starve_d = starve_full ? '0 : starve_q + SC_W'(1);
      end else if (rd_fire) begin
         starve_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Banks
   // ---------------------------------------------------------------------------
   logic [SRAM_WIDTH-1:0] bweb;
   logic [SRAM_WIDTH-1:0] bank_q [NUM_BANK];

   always_comb begin
      bweb = '1;
      for (int i = 0; i < SRAM_BYTE; i++) begin
         bweb[i*SRAM_BIT +: SRAM_BIT] = {SRAM_BIT{~wr_be[i]}};
      end
   end

   for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
      logic             wr_sel, rd_sel;
      logic [ROW_W-1:0] bank_a;

      assign wr_sel = wr_fire & (wr_bank == BANK_W'(b));
      assign rd_sel = rd_fire & (rd_bank == BANK_W'(b));
      // Arbitration guarantees at most one of wr_sel/rd_sel per bank.
      assign bank_a = wr_sel ? wr_row : rd_row;

      ram_sp_bank #(
         .WIDTH (SRAM_WIDTH),
         .DEPTH (DEPTH),
         .AW    (ROW_W)
      ) u_bank (
         .clk  (clk),
         .ceb  (~(wr_sel | rd_sel)),
         .web  (~wr_sel),
         .bweb (bweb),
         .a    (bank_a),
         .d    (wr_data),
         .q    (bank_q[b])
      );
   end

   // ---------------------------------------------------------------------------
   // Read return: bank select follows the data by one cycle
   // ---------------------------------------------------------------------------
   logic                  rd_vld_q;
   logic [BANK_W-1:0]     rd_bank_q;
   logic [SRAM_WIDTH-1:0] mux_data;
   logic [SRAM_WIDTH-1:0] lock_q, lock_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_q  <= 1'b0;
         rd_bank_q <= '0;
      end else begin
         rd_vld_q <= rd_fire;
         if (rd_fire) begin
            rd_bank_q <= rd_bank;
         end
      end
   end

   always_comb begin
      mux_data = '0;
      for (int b = 0; b < NUM_BANK; b++) begin
         if (rd_bank_q == BANK_W'(b)) begin
            mux_data = bank_q[b];
         end
      end
   end

   // Lock register keeps the last returned word while no new read arrives.
   assign lock_d = rd_vld_q ? mux_data : lock_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q <= '0;
      end else begin
         lock_q <= lock_d;
      end
   end

`ifdef RAM_OUT_REG_EN
   // Extra stage: the lock register doubles as the output data register.
   logic out_vld_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q <= 1'b0;
      end else begin
         out_vld_q <= rd_vld_q;
      end
   end

   assign rd_dvld = out_vld_q;
   assign rd_data = lock_q;
`else
   assign rd_dvld = rd_vld_q;
   assign rd_data = lock_d;
`endif

endmodule
